// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Y86-64 memory stage. Performs the data-memory access for
//               rmmovq/mrmovq/call/ret/pushq/popq over a req/ack port and
//               returns valM plus the Y86 status code. Valid/ready on both
//               sides; halt and error outcomes are sticky until reset.
//               Optional build macro MEM_BOUNDS_CHECK_EN rejects accesses
//               whose 8-byte window would run past MEM_BYTES.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int MEM_BYTES   = 8192,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valM,
    output logic [2:0]  stat,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    localparam logic [3:0] c_IHALT   = 4'h0;
    localparam logic [3:0] c_IRMMOVQ = 4'h4;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHQ  = 4'hA;
    localparam logic [3:0] c_IPOPQ   = 4'hB;

    localparam int               c_CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Highest legal start address of an 8-byte access.
    localparam logic [63:0] c_MAX_ADDR = 64'(MEM_BYTES - 8);

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic c_BOUNDS_EN = 1'b1;
`else
    localparam logic c_BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [63:0]        r_valm;
    logic [2:0]         r_stat;
    logic               r_req;
    logic               r_we;
    logic [63:0]        r_addr;
    logic [63:0]        r_wdata;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_is_write;
    logic               w_is_read;
    logic               w_is_mem;
    logic               w_oob;
    logic [63:0]        w_addr;
    logic [63:0]        w_wdata;
    logic [2:0]         w_noop_stat;

    // Decode the incoming instruction: access kind, address, data, no-op status.
    always_comb begin
        w_is_write  = 1'b0;
        w_is_read   = 1'b0;
        w_addr      = valE;
        w_wdata     = valA;
        w_noop_stat = c_STAT_AOK;
        case (icode)
            c_IRMMOVQ, c_IPUSHQ: w_is_write = 1'b1;
            c_ICALL: begin
                w_is_write = 1'b1;
                w_wdata    = valP;
            end
            c_IMRMOVQ: w_is_read = 1'b1;
            c_IRET, c_IPOPQ: begin
                w_is_read = 1'b1;
                w_addr    = valA;
            end
            c_IHALT: w_noop_stat = c_STAT_HLT;
            default: begin
                if (icode > c_IPOPQ) begin
                    w_noop_stat = c_STAT_INS;
                end
            end
        endcase
    end

    assign w_is_mem = w_is_write | w_is_read;
    // Unsigned compare against the last legal start address avoids addr+8 wrap.
    assign w_oob    = c_BOUNDS_EN & w_is_mem & (w_addr > c_MAX_ADDR);

    // Stage FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_valm      <= 64'd0;
            r_stat      <= c_STAT_AOK;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 64'd0;
            r_wdata     <= 64'd0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_is_mem && !w_oob) begin
                            r_state <= S_ACCESS;
                            r_req   <= 1'b1;
                            r_we    <= w_is_write;
                            r_addr  <= w_addr;
                            r_wdata <= w_wdata;
                            r_cnt   <= '0;
                        end else begin
                            r_state     <= S_RESP;
                            r_out_valid <= 1'b1;
                            r_valm      <= 64'd0;
                            r_stat      <= w_is_mem ? c_STAT_ADR : w_noop_stat;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack in the final allowed cycle still wins over timeout.
                    if (dmem_ack) begin
                        r_state     <= S_RESP;
                        r_out_valid <= 1'b1;
                        r_valm      <= r_we ? 64'd0 : dmem_rdata;
                        r_stat      <= c_STAT_AOK;
                        r_req       <= 1'b0;
                        r_we        <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state     <= S_RESP;
                        r_out_valid <= 1'b1;
                        r_valm      <= 64'd0;
                        r_stat      <= c_STAT_ADR;
                        r_req       <= 1'b0;
                        r_we        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_stat == c_STAT_AOK) begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= S_STOP;
                        end
                    end
                end
                default: begin
                    // STOP: frozen until reset, stat keeps the fault code.
                    r_state     <= S_STOP;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign valM       = r_valm;
    assign stat       = r_stat;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;

endmodule
`default_nettype wire
